// File: rtl/freq_sweep_controller.sv
// -----------------------------------------------------------------------------
// freq_sweep_controller
//
// Programmable frequency-sweep sequencer feeding the i_freq_control input of
// complex_sinusoid_ddfs. Steps a phase increment from a start word towards an
// inclusive stop word. Each value is held for a programmable number of dwell
// cycles. Runs single-shot or continuous (auto-restart), with hold and abort.
//
// Optional feature (compile-time macro FREQ_SWEEP_DOWN_EN):
//   When defined, adds i_dir. It is latched at start, and 1 selects a downward
//   sweep: next = current - step, valid while there is no borrow and
//   next >= stop. When undefined, sweeps are upward only.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst_n         synchronous active-low reset
//   i_start         start pulse, honoured only in IDLE
//   i_stop          abort, honoured in RUN/HOLD; also vetoes a start in IDLE
//   i_hold          level; freezes the dwell count during a run
//   i_mode          0 = single-shot, 1 = continuous (latched at start)
//   i_dir           (FREQ_SWEEP_DOWN_EN only) 1 = downward (latched at start)
//   i_start_freq    first control word (latched at start)
//   i_stop_freq     inclusive sweep limit (latched at start)
//   i_step          increment per step (latched at start)
//   i_dwell         cycles per value, 0 treated as 1 (latched at start)
//   o_freq_control  control word to the DDFS
//   o_busy          high in RUN and HOLD
//   o_step_strobe   pulse in the first cycle of each new output value
//   o_wrap          pulse when continuous mode reloads the start word
//   o_done          pulse when a single-shot sweep completes normally
// -----------------------------------------------------------------------------
module freq_sweep_controller #(
    parameter int FREQ_W  = 32,
    parameter int DWELL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_hold,
    input  logic              i_mode,
`ifdef FREQ_SWEEP_DOWN_EN
    input  logic              i_dir,
`endif
    input  logic [FREQ_W-1:0]  i_start_freq,
    input  logic [FREQ_W-1:0]  i_stop_freq,
    input  logic [FREQ_W-1:0]  i_step,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [FREQ_W-1:0]  o_freq_control,
    output logic              o_busy,
    output logic              o_step_strobe,
    output logic              o_wrap,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t              state_q;
    logic [FREQ_W-1:0]   freq_q;
    logic                busy_q;
    logic                strobe_q;
    logic                wrap_q;
    logic                done_q;
    logic [DWELL_W-1:0]  cnt_q;

    // Configuration captured at start.
    logic                mode_q;
    logic [FREQ_W-1:0]   start_q;
    logic [FREQ_W-1:0]   limit_q;
    logic [FREQ_W-1:0]   step_q;
    logic [DWELL_W-1:0]  dwell_q;
`ifdef FREQ_SWEEP_DOWN_EN
    logic                dir_q;
`endif

    // Candidate for the next output value, and whether it may be used.
    logic [FREQ_W-1:0]   next_freq_d;
    logic                next_ok_d;

    // Counter reload value: the count runs reload..0, which gives max(d,1)
    // cycles per value.
    function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    // The extra top bit catches the carry (or borrow), so a wrapped sum is
    // never mistaken for a valid value below the limit.
    logic [FREQ_W:0] sum_up;
    assign sum_up = {1'b0, freq_q} + {1'b0, step_q};

`ifdef FREQ_SWEEP_DOWN_EN
    logic [FREQ_W:0] diff_dn;
    assign diff_dn = {1'b0, freq_q} - {1'b0, step_q};
`endif

    always_comb begin
        next_freq_d = sum_up[FREQ_W-1:0];
        next_ok_d   = !sum_up[FREQ_W] && (sum_up[FREQ_W-1:0] <= limit_q);
`ifdef FREQ_SWEEP_DOWN_EN
        if (dir_q) begin
            next_freq_d = diff_dn[FREQ_W-1:0];
            next_ok_d   = !diff_dn[FREQ_W] && (diff_dn[FREQ_W-1:0] >= limit_q);
        end
`endif
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            freq_q   <= '0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            start_q  <= '0;
            limit_q  <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
`ifdef FREQ_SWEEP_DOWN_EN
            dir_q    <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low here so each is high for exactly
            // one cycle unless a branch below re-asserts it.
            strobe_q <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    // Stop vetoes a coincident start; o_freq_control holds.
                    if (i_start && !i_stop) begin
                        mode_q   <= i_mode;
                        start_q  <= i_start_freq;
                        limit_q  <= i_stop_freq;
                        step_q   <= i_step;
                        dwell_q  <= i_dwell;
`ifdef FREQ_SWEEP_DOWN_EN
                        dir_q    <= i_dir;
`endif
                        freq_q   <= i_start_freq;
                        strobe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= dwell_reload(i_dwell);
                        state_q  <= ST_RUN;
                    end
                end

                ST_RUN, ST_HOLD: begin
                    if (i_stop) begin
                        // Abort beats everything, including expiry.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (i_hold && (cnt_q != '0)) begin
                        // Freeze. An expiring count is not held off, so a
                        // hold never stretches the step due on this edge.
                        state_q <= ST_HOLD;
                    end else begin
                        // Leaving HOLD resumes counting on the release edge.
                        state_q <= ST_RUN;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - DWELL_W'(1);
                        end else if (next_ok_d) begin
                            freq_q   <= next_freq_d;
                            strobe_q <= 1'b1;
                            cnt_q    <= dwell_reload(dwell_q);
                        end else if (mode_q) begin
                            freq_q   <= start_q;
                            strobe_q <= 1'b1;
                            wrap_q   <= 1'b1;
                            cnt_q    <= dwell_reload(dwell_q);
                        end else begin
                            // Single-shot end: keep the last valid value.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_freq_control = freq_q;
    assign o_busy         = busy_q;
    assign o_step_strobe  = strobe_q;
    assign o_wrap         = wrap_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_freq_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_freq_sweep_controller
//
// Self-checking bench for freq_sweep_controller. Expected behaviour comes from
// a sweep model. The model lists the values a sweep visits using plain 64-bit
// arithmetic. It expands each value into max(dwell,1) observation cycles and
// appends the done / wrap / abort cycles. Directed scenarios add fixed
// expectations for overflow, hold, stop-at-expiry and reset mid-run.
// Build with +define+FREQ_SWEEP_DOWN_EN to add the downward-sweep checks.
// -----------------------------------------------------------------------------
module tb_freq_sweep_controller;

    localparam int FREQ_W  = 32;
    localparam int DWELL_W = 16;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic              busy;
        logic              strobe;
        logic              wrap;
        logic              done;
    } obs_t;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic               i_start;
    logic               i_stop;
    logic               i_hold;
    logic               i_mode;
`ifdef FREQ_SWEEP_DOWN_EN
    logic               i_dir;
`endif
    logic [FREQ_W-1:0]  i_start_freq;
    logic [FREQ_W-1:0]  i_stop_freq;
    logic [FREQ_W-1:0]  i_step;
    logic [DWELL_W-1:0] i_dwell;
    logic [FREQ_W-1:0]  o_freq_control;
    logic               o_busy;
    logic               o_step_strobe;
    logic               o_wrap;
    logic               o_done;

    freq_sweep_controller #(
        .FREQ_W (FREQ_W),
        .DWELL_W(DWELL_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_hold        (i_hold),
        .i_mode        (i_mode),
`ifdef FREQ_SWEEP_DOWN_EN
        .i_dir         (i_dir),
`endif
        .i_start_freq  (i_start_freq),
        .i_stop_freq   (i_stop_freq),
        .i_step        (i_step),
        .i_dwell       (i_dwell),
        .o_freq_control(o_freq_control),
        .o_busy        (o_busy),
        .o_step_strobe (o_step_strobe),
        .o_wrap        (o_wrap),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    obs_t exp_q[$];
    obs_t got_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic obs_t sample();
        return {o_freq_control, o_busy, o_step_strobe, o_wrap, o_done};
    endfunction

    // Sweep model: enumerate visited values, then expand them into cycles.
    function automatic void build_expected(input logic [31:0] s, input logic [31:0] lim,
                                           input logic [31:0] stp, input int dwell,
                                           input bit cont, input bit down, input int laps);
        logic [31:0] vals[$];
        longint      v;
        longint      nxt;
        int          eff;
        vals.delete();
        exp_q.delete();
        v = longint'({32'b0, s});
        vals.push_back(s);
        while (vals.size() < 4096) begin
            nxt = down ? v - longint'({32'b0, stp}) : v + longint'({32'b0, stp});
            // The limit lies in 0..2^32-1, so these bounds also reject carry and borrow.
            if (down ? (nxt < longint'({32'b0, lim})) : (nxt > longint'({32'b0, lim}))) break;
            v = nxt;
            vals.push_back(v[31:0]);
        end
        eff = (dwell == 0) ? 1 : dwell;
        for (int lap = 0; lap < (cont ? laps : 1); lap++)
            for (int i = 0; i < vals.size(); i++)
                for (int c = 0; c < eff; c++)
                    exp_q.push_back({vals[i], 1'b1, c == 0, (c == 0) && (i == 0) && (lap > 0), 1'b0});
        if (cont) begin
            exp_q.push_back({vals[0], 1'b1, 1'b1, 1'b1, 1'b0});
            exp_q.push_back({vals[0], 1'b0, 1'b0, 1'b0, 1'b0}); // after abort
        end else begin
            exp_q.push_back({vals[vals.size()-1], 1'b0, 1'b0, 1'b0, 1'b1});
            exp_q.push_back({vals[vals.size()-1], 1'b0, 1'b0, 1'b0, 1'b0});
        end
    endfunction

    // Starts a sweep from IDLE and compares every cycle against the model. A
    // continuous sweep is aborted once the model's laps have been observed.
    // Inputs are scrambled after start to confirm the configuration is latched.
    task automatic run_sweep(input string tag, input logic [31:0] s, input logic [31:0] lim,
                             input logic [31:0] stp, input int dwell, input bit cont,
                             input bit down, input int laps);
        obs_t g;
        int   n;
        build_expected(s, lim, stp, dwell, cont, down, laps);
        got_q.delete();
        n = exp_q.size();
        i_start_freq = s;
        i_stop_freq  = lim;
        i_step       = stp;
        i_dwell      = DWELL_W'(dwell);
        i_mode       = cont;
`ifdef FREQ_SWEEP_DOWN_EN
        i_dir        = down;
`endif
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            g = sample();
            got_q.push_back(g);
            check($sformatf("%s[%0d]", tag, k), 64'(g), 64'(exp_q[k]));
            i_start_freq = $urandom;
            i_stop_freq  = $urandom;
            i_step       = $urandom;
            i_dwell      = DWELL_W'($urandom);
            i_mode       = 1'($urandom);
`ifdef FREQ_SWEEP_DOWN_EN
            i_dir        = 1'($urandom);
`endif
            i_start = (k < n - (cont ? 1 : 2)) ? 1'($urandom) : 1'b0;
            i_stop  = cont && (k == n - 2);
        end
        i_stop  = 1'b0;
        i_start = 1'b0;
    endtask

    initial begin
        logic [31:0] s, lim, stp;
        longint      lim_l;
        int          sel, dwell, held, first_new;
        bit          cont, down;

        i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_hold = 1'b0; i_mode = 1'b0;
        i_start_freq = '0; i_stop_freq = '0; i_step = '0; i_dwell = '0;
`ifdef FREQ_SWEEP_DOWN_EN
        i_dir = 1'b0;
`endif
        repeat (3) @(negedge i_clk);
        check("reset_outputs", 64'(sample()), 64'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("idle_after_reset", 64'(sample()), 64'(0));

        // Basic single-shot: five values, three cycles each.
        run_sweep("basic", 32'h000F_FFFF, 32'h004F_FFFF, 32'h0010_0000, 3, 1'b0, 1'b0, 1);
        held = 0;
        foreach (got_q[i]) if (got_q[i].strobe) held++;
        check("basic_strobes", 64'(held), 64'(5));
        check("basic_done_at_15", 64'(got_q[15].done), 64'(1));
        check("basic_last_value", 64'(got_q[15].freq), 64'(32'h004F_FFFF));
        check("basic_busy_drop", 64'(got_q[16].busy), 64'(0));

        // Overflow: the first step carries out, so only the start word appears.
        run_sweep("ovf", 32'hFFF0_0000, 32'hFFFF_FFFF, 32'h0010_0000, 1, 1'b0, 1'b0, 1);
        check("ovf_first", 64'(got_q[0].freq), 64'(32'hFFF0_0000));
        check("ovf_done", 64'(got_q[1].done), 64'(1));
        check("ovf_hold_value", 64'(got_q[2].freq), 64'(32'hFFF0_0000));

        // Continuous: a wrap coincides with a strobe every 15 cycles.
        run_sweep("cont", 32'h000F_FFFF, 32'h004F_FFFF, 32'h0010_0000, 3, 1'b1, 1'b0, 2);
        check("cont_wrap15", 64'({got_q[15].wrap, got_q[15].strobe}), 64'(2'b11));
        check("cont_wrap15_val", 64'(got_q[15].freq), 64'(32'h000F_FFFF));
        check("cont_wrap30", 64'(got_q[30].wrap), 64'(1));
        check("cont_no_wrap14", 64'(got_q[14].wrap), 64'(0));

        // Hold for 5 cycles mid-dwell, then stop exactly at the next expiry.
        i_start_freq = 32'h100; i_stop_freq = 32'h1000; i_step = 32'h10;
        i_dwell = 16'd10; i_mode = 1'b0;
`ifdef FREQ_SWEEP_DOWN_EN
        i_dir = 1'b0;
`endif
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        held = 0;
        first_new = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge i_clk);
            if (c == 5) check("hold_busy", 64'({o_busy, o_freq_control}), 64'({1'b1, 32'h100}));
            if (o_step_strobe && c > 1) begin
                first_new = c;
                break;
            end
            if (o_freq_control == 32'h100) held++;
            if (c == 3) i_hold = 1'b1;
            if (c == 8) i_hold = 1'b0;
        end
        i_hold = 1'b0;
        check("hold_len", 64'(held), 64'(15));
        check("hold_next_val", 64'(o_freq_control), 64'(32'h110));
        if (first_new != 0) begin
            // The new value was seen in cycle 1 of its dwell; its 10th cycle
            // is 9 cycles later.
            repeat (9) @(negedge i_clk);
            i_stop = 1'b1;
            @(negedge i_clk);
            i_stop = 1'b0;
            check("stop_at_expiry", 64'(sample()), 64'({32'h110, 4'b0000}));
        end
        @(negedge i_clk);
        check("stop_stays_idle", 64'(sample()), 64'({32'h110, 4'b0000}));

        // Reset mid-run with start held through the reset.
        i_start_freq = 32'h0123_4567; i_stop_freq = 32'hF000_0000; i_step = 32'h100;
        i_dwell = 16'd2; i_mode = 1'b1;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        check("pre_reset_busy", 64'(o_busy), 64'(1));
        i_rst_n = 1'b0;
        i_start = 1'b1;
        @(negedge i_clk);
        check("rst_mid_run", 64'(sample()), 64'(0));
        @(negedge i_clk);
        check("rst_start_ignored", 64'(sample()), 64'(0));
        i_rst_n = 1'b1;
        i_start = 1'b0;
        @(negedge i_clk);
        check("rst_release_idle", 64'(sample()), 64'(0));
        run_sweep("restart", 32'h000F_FFFF, 32'h004F_FFFF, 32'h0010_0000, 3, 1'b0, 1'b0, 1);

`ifdef FREQ_SWEEP_DOWN_EN
        run_sweep("down", 32'h0040_0000, 32'h0020_0000, 32'h0010_0000, 2, 1'b0, 1'b1, 1);
        check("down_third", 64'(got_q[4].freq), 64'(32'h0020_0000));
        check("down_done", 64'(got_q[6].done), 64'(1));
`endif

        // Randomised sweeps: normal, near-overflow, and start above stop.
        for (int it = 0; it < 30; it++) begin
            sel   = $urandom_range(0, 2);
            stp   = $urandom_range(1, 32'h0010_0000);
            dwell = $urandom_range(0, 4);
            cont  = 1'($urandom);
            down  = 1'b0;
`ifdef FREQ_SWEEP_DOWN_EN
            down  = 1'($urandom);
`endif
            s = $urandom;
            if (down) begin
                lim_l = longint'({32'b0, s}) - longint'($urandom_range(0, 5)) * longint'({32'b0, stp})
                        - longint'($urandom_range(0, 100));
                lim   = (lim_l < 0) ? 32'h0 : lim_l[31:0];
            end else if (sel == 0) begin
                lim_l = longint'({32'b0, s}) + longint'($urandom_range(0, 5)) * longint'({32'b0, stp})
                        + longint'($urandom_range(0, 100));
                lim   = (lim_l > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : lim_l[31:0];
            end else if (sel == 1) begin
                s   = 32'hFFFF_FFFF - $urandom_range(0, 4 * stp);
                lim = 32'hFFFF_FFFF;
            end else begin
                s   = $urandom_range(1000, 32'h7FFF_FFFF);
                lim = s - $urandom_range(1, 500);
            end
            run_sweep($sformatf("rand%0d", it), s, lim, stp, dwell, cont, down, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
